sum_accum_int: RTL and testbench

SUM_ACCUM_INT -- requirements
Module: sum_accum_int

---
 rtl/sum_accum_int.sv | 121 ++++++++++++
 tb/tb_sum_accum_int.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum_int.sv
// sum_accum_int: accumulates num_chunks signed partial sums into one result.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_clear              synchronous flush of the in-progress accumulation
//   i_valid, i_sum       incoming partial-sum beat
//   o_in_ready           beat may be accepted this cycle (ACC state)
//   o_valid, o_sum       completed result; held while o_valid && !i_ready
//   i_ready              downstream consumes o_sum this cycle
//   o_busy               a partial accumulation or a parked result is pending
module sum_accum_int #(
    parameter int sum_width  = 21,
    parameter int num_chunks = 4,
    parameter int acc_width  = sum_width + $clog2(num_chunks)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic                        i_valid,
    input  logic signed [sum_width-1:0] i_sum,
    output logic                        o_in_ready,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_sum,
    output logic                        o_busy
);

    localparam int unsigned cnt_w = (num_chunks > 1) ? $clog2(num_chunks) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic signed [acc_width-1:0]  acc_q, acc_d;
    logic        [cnt_w-1:0]      cnt_q, cnt_d;
    logic                         valid_d;
    logic signed [acc_width-1:0]  sum_d;

    logic signed [acc_width-1:0]  sum_ext;
    logic signed [acc_width-1:0]  acc_plus;
    logic                         accept;
    logic                         last_beat;
    logic                         slot_free;

    // Sign-extended operand; widths guarantee the sum never overflows.
    assign sum_ext   = acc_width'(i_sum);
    assign acc_plus  = acc_q + sum_ext;
    assign accept    = i_valid && (state_q == ST_ACC) && !i_clear;
    assign last_beat = (cnt_q == last_cnt);
    assign slot_free = !o_valid || i_ready;

    // Status decoded directly from state flops, independent of i_ready.
    assign o_in_ready = (state_q == ST_ACC);
    assign o_busy     = (cnt_q != '0) || (state_q == ST_WAIT);

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_valid <= 1'b0;
            o_sum   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_valid <= valid_d;
            o_sum   <= sum_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = o_valid && !i_ready;
        sum_d   = o_sum;

        if (i_clear) begin
            // Flush partial and parked sums; the output handshake still runs.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (!last_beat) begin
                            acc_d = acc_plus;
                            cnt_d = cnt_q + cnt_w'(1);
                        end else if (slot_free) begin
                            sum_d   = acc_plus;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            // Output slot busy: park the finished sum in acc.
                            acc_d   = acc_plus;
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_ready) begin
                        sum_d   = acc_q;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accum_int.sv
// Directed bench for sum_accum_int with a result scoreboard per instance.
module tb_sum_accum_int;

    localparam int SW  = 21;
    localparam int AW4 = 23;
    localparam int AW1 = 21;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;

    logic                  i_clear, i_valid, i_ready;
    logic signed [SW-1:0]  i_sum;
    logic                  o_in_ready, o_valid, o_busy;
    logic signed [AW4-1:0] o_sum;

    logic                  i_clear1, i_valid1, i_ready1;
    logic signed [SW-1:0]  i_sum1;
    logic                  o_in_ready1, o_valid1, o_busy1;
    logic signed [AW1-1:0] o_sum1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp1_q[$];

    always #5 i_clk = ~i_clk;

    sum_accum_int #(.sum_width(SW), .num_chunks(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_valid(i_valid), .i_sum(i_sum), .o_in_ready(o_in_ready),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_busy(o_busy)
    );

    sum_accum_int #(.sum_width(SW), .num_chunks(1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear1),
        .i_valid(i_valid1), .i_sum(i_sum1), .o_in_ready(o_in_ready1),
        .o_valid(o_valid1), .i_ready(i_ready1), .o_sum(o_sum1), .o_busy(o_busy1)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard compare at negedge, then advance past posedge.
    task automatic cycle();
        @(negedge i_clk);
        if (o_valid) begin
            if (exp_q.size() > 0) begin
                chk("sb4_sum", 32'(o_sum), exp_q[0]);
                if (i_ready) void'(exp_q.pop_front());
            end else begin
                chk("sb4_spurious_valid", 32'(o_valid), 0);
            end
        end
        if (o_valid1) begin
            if (exp1_q.size() > 0) begin
                chk("sb1_sum", 32'(o_sum1), exp1_q[0]);
                if (i_ready1) void'(exp1_q.pop_front());
            end else begin
                chk("sb1_spurious_valid", 32'(o_valid1), 0);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input int s);
        i_valid = 1'b1;
        i_sum   = SW'(s);
        cycle();
    endtask

    task automatic idle();
        i_valid = 1'b0;
        cycle();
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_clear  = 1'b0; i_valid  = 1'b0; i_ready  = 1'b1; i_sum  = '0;
        i_clear1 = 1'b0; i_valid1 = 1'b0; i_ready1 = 1'b1; i_sum1 = '0;

        // Reset state
        #12;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_sum", 32'(o_sum), 0);
        chk("rst_in_ready", 32'(o_in_ready), 1);
        chk("rst_busy", 32'(o_busy), 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Basic sum, one-cycle latency, single-cycle valid
        beat(100);
        beat(-30);
        chk("busy_mid", 32'(o_busy), 1);
        beat(7);
        exp_q.push_back(78);
        beat(1);
        chk("lat_valid", 32'(o_valid), 1);
        chk("lat_sum", 32'(o_sum), 78);
        chk("lat_busy", 32'(o_busy), 0);
        idle();
        chk("one_cycle_valid", 32'(o_valid), 0);

        // Extremes, back to back
        beat(-1048576); beat(-1048576); beat(-1048576);
        exp_q.push_back(-4194304);
        beat(-1048576);
        chk("min_sum", 32'(o_sum), -4194304);
        beat(1048575); beat(1048575); beat(1048575);
        exp_q.push_back(4194300);
        beat(1048575);
        chk("max_sum", 32'(o_sum), 4194300);
        idle();

        // Backpressure: held result, then WAIT
        i_ready = 1'b0;
        beat(100); beat(-30); beat(7);
        exp_q.push_back(78);
        beat(1);
        beat(5); beat(5); beat(5);
        exp_q.push_back(20);
        beat(5);
        chk("wait_in_ready", 32'(o_in_ready), 0);
        chk("wait_busy", 32'(o_busy), 1);
        chk("wait_hold_valid", 32'(o_valid), 1);
        chk("wait_hold_sum", 32'(o_sum), 78);
        beat(777);
        chk("wait_stays", 32'(o_in_ready), 0);
        i_ready = 1'b1;
        beat(777);
        chk("wait_release_sum", 32'(o_sum), 20);
        chk("wait_release_valid", 32'(o_valid), 1);
        chk("wait_release_in_ready", 32'(o_in_ready), 1);
        idle();
        chk("wait_no_consume_busy", 32'(o_busy), 0);
        chk("wait_drop_valid", 32'(o_valid), 0);

        // Clear discards partial sum and same-cycle beat
        beat(10);
        beat(20);
        i_clear = 1'b1;
        beat(99);
        i_clear = 1'b0;
        chk("clear_busy", 32'(o_busy), 0);
        beat(1); beat(1); beat(1);
        exp_q.push_back(4);
        beat(1);
        chk("clear_sum", 32'(o_sum), 4);
        idle();

        // Reset mid-accumulation with a held result
        i_ready = 1'b0;
        beat(3); beat(3); beat(3);
        exp_q.push_back(12);
        beat(3);
        beat(2);
        beat(2);
        chk("pre_rst_valid", 32'(o_valid), 1);
        i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_sum", 32'(o_sum), 0);
        chk("mid_rst_in_ready", 32'(o_in_ready), 1);
        chk("mid_rst_busy", 32'(o_busy), 0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        beat(2); beat(2); beat(2);
        exp_q.push_back(8);
        beat(2);
        chk("post_rst_sum", 32'(o_sum), 8);
        idle();

        // num_chunks = 1: every beat completes a result
        i_valid1 = 1'b1;
        i_sum1   = SW'(3);
        exp1_q.push_back(3);
        cycle();
        chk("n1_valid_a", 32'(o_valid1), 1);
        chk("n1_sum_a", 32'(o_sum1), 3);
        i_sum1 = SW'(-4);
        exp1_q.push_back(-4);
        cycle();
        chk("n1_valid_b", 32'(o_valid1), 1);
        chk("n1_sum_b", 32'(o_sum1), -4);
        i_valid1 = 1'b0;
        cycle();
        chk("n1_valid_drop", 32'(o_valid1), 0);

        idle();
        idle();
        chk("sb4_drained", exp_q.size(), 0);
        chk("sb1_drained", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
